// File: rtl/rpn_pkg.sv
// Shared constants and encodings for the RPN evaluator: ASCII codes, FSM states, operators.
package rpn_pkg;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        EXEC = 2'd2,
        EMIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    function automatic logic is_digit(input logic [7:0] ch);
        return (ch >= CH_0) && (ch <= CH_9);
    endfunction

    function automatic logic is_op(input logic [7:0] ch);
        return (ch == CH_PLUS) || (ch == CH_MINUS) || (ch == CH_STAR);
    endfunction

    function automatic op_t op_of(input logic [7:0] ch);
        op_t op;
        op = OP_ADD;
        if (ch == CH_MINUS)
            op = OP_SUB;
        else if (ch == CH_STAR)
            op = OP_MUL;
        return op;
    endfunction

endpackage

// File: rtl/rpn_stack.sv
// Fixed-depth operand stack: push a value, or replace the top two entries with one.
module rpn_stack
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       replace2,
    input  logic [WIDTH-1:0]           replace_data,
    output logic [WIDTH-1:0]           top,
    output logic [WIDTH-1:0]           next,
    output logic [$clog2(DEPTH):0]     sp,
    output logic                       full,
    output logic                       empty
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_d;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    next_idx;
    logic             can_pop2;

    assign wr_idx   = AW'(sp_q);
    assign top_idx  = AW'(sp_q - SPW'(1));
    assign next_idx = AW'(sp_q - SPW'(2));
    assign can_pop2 = sp_q >= SPW'(2);

    assign full  = sp_q == SPW'(DEPTH);
    assign empty = sp_q == '0;
    assign sp    = sp_q;
    assign top   = mem_q[top_idx];
    assign next  = mem_q[next_idx];

    always_comb begin
        sp_d = sp_q;
        if (clear)
            sp_d = '0;
        else if (push && !full)
            sp_d = sp_q + SPW'(1);
        else if (replace2 && can_pop2)
            sp_d = sp_q - SPW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sp_q <= '0;
        else
            sp_q <= sp_d;
    end

    // Storage carries no reset; only entries below sp are ever read meaningfully.
    always_ff @(posedge clk) begin
        if (!clear && push && !full)
            mem_q[wr_idx] <= push_data;
        else if (!clear && replace2 && can_pop2)
            mem_q[next_idx] <= replace_data;
    end

endmodule

// File: rtl/rpn_evaluator.sv
// RPN expression evaluator: parses ASCII digits/operators, evaluates on a stack, emits per line.
module rpn_evaluator
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             err
);

    localparam int SPW = $clog2(DEPTH) + 1;

    state_t           state_q, state_d;
    state_t           after_q, after_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             num_q, num_d;
    logic             err_flag_q, err_flag_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             rv_q, rv_d;
    logic             err_q, err_d;

    logic             st_clear;
    logic             st_push;
    logic             st_replace2;
    logic [WIDTH-1:0] st_top;
    logic [WIDTH-1:0] st_next;
    logic [SPW-1:0]   sp;
    logic             st_full;
    logic             st_empty;
    logic [WIDTH-1:0] alu_out;

    function automatic logic [WIDTH-1:0] alu(input op_t op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    assign alu_out = alu(op_q, st_next, st_top);

    rpn_stack #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_stack (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (st_clear),
        .push         (st_push),
        .push_data    (acc_q),
        .replace2     (st_replace2),
        .replace_data (alu_out),
        .top          (st_top),
        .next         (st_next),
        .sp           (sp),
        .full         (st_full),
        .empty        (st_empty)
    );

    always_comb begin
        state_d     = state_q;
        after_d     = after_q;
        op_d        = op_q;
        acc_d       = acc_q;
        num_d       = num_q;
        err_flag_d  = err_flag_q;
        result_d    = result_q;
        rv_d        = 1'b0;
        err_d       = 1'b0;
        st_clear    = 1'b0;
        st_push     = 1'b0;
        st_replace2 = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (is_digit(rx_data)) begin
                        acc_d = acc_q * WIDTH'(10) + WIDTH'(rx_data[3:0]);
                        num_d = 1'b1;
                    end else if (rx_data == CH_SP) begin
                        if (num_q) begin
                            state_d = PUSH;
                            after_d = IDLE;
                        end
                    end else if (is_op(rx_data)) begin
                        op_d = op_of(rx_data);
                        if (num_q) begin
                            state_d = PUSH;
                            after_d = EXEC;
                        end else begin
                            state_d = EXEC;
                        end
                    end else if (rx_data == CH_CR || rx_data == CH_LF) begin
                        if (num_q) begin
                            state_d = PUSH;
                            after_d = EMIT;
                        end else begin
                            state_d = EMIT;
                        end
                    end else begin
                        err_flag_d = 1'b1;
                    end
                end
            end
            PUSH: begin
                if (st_full)
                    err_flag_d = 1'b1;
                else
                    st_push = 1'b1;
                acc_d   = '0;
                num_d   = 1'b0;
                state_d = after_q;
                if (rx_valid)
                    err_flag_d = 1'b1;
            end
            EXEC: begin
                if (sp < SPW'(2))
                    err_flag_d = 1'b1;
                else
                    st_replace2 = 1'b1;
                state_d = IDLE;
                if (rx_valid)
                    err_flag_d = 1'b1;
            end
            EMIT: begin
                if (!err_flag_q && sp == SPW'(1)) begin
                    result_d = st_top;
                    rv_d     = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                st_clear = 1'b1;
                acc_d    = '0;
                num_d    = 1'b0;
                // An overrun during EMIT belongs to the next line, so it survives the clear.
                err_flag_d = rx_valid;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            after_q    <= IDLE;
            op_q       <= OP_ADD;
            acc_q      <= '0;
            num_q      <= 1'b0;
            err_flag_q <= 1'b0;
            result_q   <= '0;
            rv_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            after_q    <= after_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            num_q      <= num_d;
            err_flag_q <= err_flag_d;
            result_q   <= result_d;
            rv_q       <= rv_d;
            err_q      <= err_d;
        end
    end

    assign result       = result_q;
    assign result_valid = rv_q;
    assign err          = err_q;

endmodule

// File: tb/tb_rpn_evaluator.sv
// Directed bench for rpn_evaluator: expected line outcomes queued on send, checked on each strobe.
module tb_rpn_evaluator;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    typedef struct {
        logic             is_err;
        logic [WIDTH-1:0] val;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             err;

    int   total;
    int   bad;
    exp_t exp_q[$];
    exp_t e;

    rpn_evaluator #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .result       (result),
        .result_valid (result_valid),
        .err          (err)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send(s[i]);
    endtask

    task automatic expect_val(input logic [WIDTH-1:0] v);
        exp_t x;
        x.is_err = 1'b0;
        x.val    = v;
        exp_q.push_back(x);
    endtask

    task automatic expect_err();
        exp_t x;
        x.is_err = 1'b1;
        x.val    = '0;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            assert (!(result_valid && err)) else begin
                bad++;
                $error("FAIL both_strobes result_valid=%0b err=%0b required=not both", result_valid, err);
            end
            if (result_valid || err) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_strobe rv=%0b err=%0b result=%0h required=no strobe",
                           result_valid, err, result);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    total++;
                    assert (err === e.is_err) else begin
                        bad++;
                        $error("FAIL strobe_kind err=%0b required err=%0b", err, e.is_err);
                    end
                    if (!e.is_err) begin
                        total++;
                        assert (result === e.val) else begin
                            bad++;
                            $error("FAIL result_value got=%0h required=%0h", result, e.val);
                        end
                    end
                end
            end
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        #3;
        total += 3;
        assert (result === '0) else begin bad++; $error("FAIL rst_result got=%0h required=0", result); end
        assert (result_valid === 1'b0) else begin bad++; $error("FAIL rst_rv got=%0b required=0", result_valid); end
        assert (err === 1'b0) else begin bad++; $error("FAIL rst_err got=%0b required=0", err); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        expect_val(16'd46);
        send_str("12 34+\n");
        total++;
        assert (dut.sp === 4'd0) else begin bad++; $error("FAIL sp_after_line got=%0d required=0", dut.sp); end

        expect_val(16'hFFFE);
        send_str("3 5-\n");
        expect_val(16'h5F90);
        send_str("300 300*\n");
        expect_val(16'h0000);
        send_str("65535 1+\n");
        expect_val(16'h1234);
        send_str("4660\n");

        expect_err();
        send_str("+\n");
        total++;
        assert (result === 16'h1234) else begin bad++; $error("FAIL result_hold got=%0h required=1234", result); end

        expect_err();
        send_str("1 2\n");

        expect_err();
        for (int i = 0; i < 9; i++)
            send_str("1 ");
        send_str("\n");
        expect_val(16'd7);
        send_str("7\n");

        expect_err();
        send_str("9");
        @(posedge clk);
        #1;
        rx_data  = 8'h2B;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_data  = 8'h35;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (4) @(posedge clk);
        send_str("\n");

        expect_val(16'd5);
        expect_err();
        send_str("5\r\n");

        expect_err();
        send_str("2x\n");

        expect_val(16'd8);
        send_str("8\n");

        send_str("123");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        total += 3;
        assert (result === '0) else begin bad++; $error("FAIL midrst_result got=%0h required=0", result); end
        assert (result_valid === 1'b0) else begin bad++; $error("FAIL midrst_rv got=%0b required=0", result_valid); end
        assert (err === 1'b0) else begin bad++; $error("FAIL midrst_err got=%0b required=0", err); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_val(16'd4);
        send_str("4\n");

        for (int i = 0; i < 50 && exp_q.size() != 0; i++)
            @(posedge clk);
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
